// File: rtl/seven_seg_pkg.sv
// Shared types, segment codes and decode helper for the 7-segment read-back capture.
package seven_seg_pkg;

  typedef logic [3:0] digit_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {SYNC, COLLECT, CHECK, CONVERT} cap_state_t;

  typedef struct packed {
    logic   valid;
    digit_t digit;
  } seg_dec_t;

  // A blank digit reads as zero so leading blanks do not break the frame
  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t r;
    r.valid = 1'b1;
    r.digit = 4'd0;
    case (seg)
      SEG_0, SEG_BLANK: r.digit = 4'd0;
      SEG_1:            r.digit = 4'd1;
      SEG_2:            r.digit = 4'd2;
      SEG_3:            r.digit = 4'd3;
      SEG_4:            r.digit = 4'd4;
      SEG_5:            r.digit = 4'd5;
      SEG_6:            r.digit = 4'd6;
      SEG_7:            r.digit = 4'd7;
      SEG_8:            r.digit = 4'd8;
      SEG_9:            r.digit = 4'd9;
      default:          r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_capture_sampler.sv
// seg_slot_sampler: synchronizes the anode/segment buses, waits for them to settle
// and emits one sample strobe per legal digit slot.
module seg_slot_sampler #(
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_select_in,
  input  logic [6:0] led_select_in,
  output logic       sample,
  output logic [1:0] digit_idx,
  output logic [6:0] seg
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  logic [3:0]    an_meta, an_sync, an_prev;
  logic [6:0]    seg_meta, seg_sync, seg_prev;
  logic [CW-1:0] settle_cnt;
  logic          taken;
  logic          changed;
  logic          legal;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_meta    <= 4'hF;
      an_sync    <= 4'hF;
      an_prev    <= 4'hF;
      seg_meta   <= 7'h7F;
      seg_sync   <= 7'h7F;
      seg_prev   <= 7'h7F;
      settle_cnt <= '0;
      taken      <= 1'b0;
    end else begin
      an_meta  <= digit_select_in;
      an_sync  <= an_meta;
      an_prev  <= an_sync;
      seg_meta <= led_select_in;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;

      if (changed || !legal)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_LAST)
        settle_cnt <= settle_cnt + 1'b1;

      // One sample per slot: only a new anode word re-arms the strobe
      if (an_sync != an_prev)
        taken <= 1'b0;
      else if (sample)
        taken <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    changed   = (an_sync != an_prev) || (seg_sync != seg_prev);
    legal     = ($countones(~an_sync) == 1);
    digit_idx = 2'd0;
    case (an_sync)
      4'b1110: digit_idx = 2'd0;
      4'b1101: digit_idx = 2'd1;
      4'b1011: digit_idx = 2'd2;
      4'b0111: digit_idx = 2'd3;
      default: digit_idx = 2'd0;
    endcase
    sample = legal && !changed && !taken && (settle_cnt == SETTLE_LAST);
    seg    = seg_sync;
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Display read-back monitor: assembles 4-digit frames, confirms repeats, publishes binary value.
// Optional: define SEG_CAPTURE_STICKY_ERR_EN to build the latched err_sticky flag.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 2**21,
  parameter int FRAMES_MATCH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit_select_in,
  input  logic [6:0]  led_select_in,
  output logic [13:0] number_out,
  output logic        number_valid,
  output logic        frame_error,
  output logic        err_sticky
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    FM       = 3'(FRAMES_MATCH);

  logic       smp;
  logic [1:0] smp_idx;
  logic [6:0] smp_seg;
  seg_dec_t   dec;

  cap_state_t        state, state_n;
  logic [1:0]        exp_idx, exp_n;
  digit_t [3:0]      frame, prev_frame;
  logic [2:0]        match_cnt, match_n;
  logic [TW-1:0]     tmo_cnt;
  logic [1:0]        conv_step;
  logic [13:0]       acc, acc_base, acc_n;
  logic              published;
  logic              err, store;

  seg_slot_sampler #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_sampler (
    .clk             (clk),
    .reset           (reset),
    .digit_select_in (digit_select_in),
    .led_select_in   (led_select_in),
    .sample          (smp),
    .digit_idx       (smp_idx),
    .seg             (smp_seg)
  );

  assign dec = seg_decode(smp_seg);

  always_comb begin
    state_n = state;
    exp_n   = exp_idx;
    match_n = match_cnt;
    err     = 1'b0;
    store   = 1'b0;
    case (state)
      SYNC: begin
        if (smp) begin
          if (!dec.valid) begin
            err     = 1'b1;
            match_n = '0;
          end else if (smp_idx == 2'd0) begin
            store   = 1'b1;
            exp_n   = 2'd1;
            state_n = COLLECT;
          end
        end
      end
      COLLECT: begin
        // A sample arriving in the timeout cycle takes precedence
        if (smp) begin
          if (!dec.valid) begin
            err     = 1'b1;
            match_n = '0;
            state_n = SYNC;
          end else if (smp_idx != exp_idx) begin
            err     = 1'b1;
            state_n = SYNC;
          end else begin
            store = 1'b1;
            exp_n = exp_idx + 2'd1;
            if (exp_idx == 2'd3) state_n = CHECK;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err     = 1'b1;
          state_n = SYNC;
        end
      end
      CHECK: begin
        if (frame == prev_frame)
          match_n = (match_cnt >= FM) ? FM : match_cnt + 3'd1;
        else
          match_n = 3'd1;
        if (match_n == FM) begin
          state_n = CONVERT;
        end else begin
          state_n = COLLECT;
          exp_n   = 2'd0;
        end
      end
      CONVERT: begin
        if (conv_step == 2'd3) begin
          state_n = COLLECT;
          exp_n   = 2'd0;
        end
      end
      default: state_n = SYNC;
    endcase
  end

  // Horner step over d3, d2, d1, d0; the first step starts from zero
  always_comb begin
    acc_base = (conv_step == 2'd0) ? 14'd0 : acc;
    acc_n    = 14'(acc_base * 14'd10) + 14'(frame[2'd3 - conv_step]);
  end

  // NOTE: the frame registers are reset along with the control state so a
  // first frame is always compared against a known previous frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SYNC;
      exp_idx      <= 2'd0;
      frame        <= '0;
      prev_frame   <= '0;
      match_cnt    <= '0;
      tmo_cnt      <= '0;
      conv_step    <= 2'd0;
      acc          <= '0;
      published    <= 1'b0;
      number_out   <= '0;
      number_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      state        <= state_n;
      exp_idx      <= exp_n;
      match_cnt    <= match_n;
      number_valid <= 1'b0;
      frame_error  <= err;

      if (store) frame[smp_idx] <= dec.digit;
      if (state == CHECK) prev_frame <= frame;

      if (state != COLLECT || smp)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;

      conv_step <= (state == CONVERT) ? conv_step + 2'd1 : 2'd0;

      if (state == CONVERT) begin
        acc <= acc_n;
        if (conv_step == 2'd3) begin
          published <= 1'b1;
          if (!published || acc_n != number_out) begin
            number_out   <= acc_n;
            number_valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SEG_CAPTURE_STICKY_ERR_EN
  logic err_sticky_q;

  always_ff @(posedge clk) begin
    if (reset)
      err_sticky_q <= 1'b0;
    else if (err)
      err_sticky_q <= 1'b1;
  end

  assign err_sticky = err_sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: frame confirm, blanks, decode/order/timeout errors, reset.
module tb_seven_seg_capture;
  import seven_seg_pkg::*;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int DWELL   = 12;

  // Independent copy of the segment table ({g..a}, active-low)
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SX = 7'b0101010;

`ifdef SEG_CAPTURE_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digit_select_in;
  logic [6:0]  led_select_in;
  logic [13:0] number_out;
  logic        number_valid;
  logic        frame_error;
  logic        err_sticky;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int t_d3 = 0;
  int t_smp = 0;
  int t_err = 0;
  int lat_valid = -1;
  int base_v, base_e;

  seven_seg_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FRAMES_MATCH   (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .digit_select_in (digit_select_in),
    .led_select_in   (led_select_in),
    .number_out      (number_out),
    .number_valid    (number_valid),
    .frame_error     (frame_error),
    .err_sticky      (err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse counters and timestamps; the sample strobe is only a timing reference
  always @(negedge clk) begin
    if (number_valid) begin
      n_valid++;
      lat_valid = cyc - t_d3;
    end
    if (frame_error) begin
      n_ferr++;
      t_err = cyc;
    end
    if (dut.smp) t_smp = cyc;
    if (dut.smp && dut.smp_idx == 2'd3) t_d3 = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic show_digit(input int idx, input logic [6:0] s);
    @(negedge clk);
    digit_select_in = ~(4'b0001 << idx);
    led_select_in   = s;
    repeat (DWELL) @(negedge clk);
    digit_select_in = 4'hF;
    led_select_in   = 7'h7F;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
    show_digit(0, d0);
    show_digit(1, d1);
    show_digit(2, d2);
    show_digit(3, d3);
  endtask

  task automatic idle(input int n);
    digit_select_in = 4'hF;
    led_select_in   = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    base_v    = n_valid;
    base_e    = n_ferr;
    lat_valid = -1;
  endtask

  initial begin
    reset           = 1'b1;
    digit_select_in = 4'hF;
    led_select_in   = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_number_out", 32'(number_out), 0);
    check("rst_valid", 32'(number_valid), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    check("rst_sticky", 32'(err_sticky), 0);
    check("rst_state", 32'(dut.state), 32'(SYNC));
    reset = 1'b0;
    idle(4);

    // "1234" twice: one publish, 6 cycles after the confirming digit-3 sample
    snap();
    drive_frame(S4, S3, S2, S1);
    drive_frame(S4, S3, S2, S1);
    idle(4);
    check("t1_valid_cnt", 32'(n_valid - base_v), 1);
    check("t1_number", 32'(number_out), 1234);
    check("t1_latency", 32'(lat_valid), 6);
    check("t1_no_err", 32'(n_ferr - base_e), 0);
    idle(100);

    // blank,blank,4,2 three times: 42 published once, unchanged third frame is silent
    snap();
    drive_frame(S2, S4, SB, SB);
    drive_frame(S2, S4, SB, SB);
    drive_frame(S2, S4, SB, SB);
    idle(4);
    check("t2_valid_cnt", 32'(n_valid - base_v), 1);
    check("t2_number", 32'(number_out), 42);
    check("t2_no_err", 32'(n_ferr - base_e), 0);
    idle(100);

    // Illegal segment pattern on digit 2
    snap();
    show_digit(0, S1);
    show_digit(1, S1);
    show_digit(2, SX);
    check("t3_err_cnt", 32'(n_ferr - base_e), 1);
    check("t3_sticky", 32'(err_sticky), 32'(STICKY));
    show_digit(3, S1);
    idle(100);
    check("t3_no_valid", 32'(n_valid - base_v), 0);
    check("t3_number_kept", 32'(number_out), 42);
    check("t3_err_total", 32'(n_ferr - base_e), 1);

    // Out-of-order digits 0,1,3 then a clean "0007" twice
    snap();
    show_digit(0, S5);
    show_digit(1, S5);
    show_digit(3, S5);
    check("t4_order_err", 32'(n_ferr - base_e), 1);
    check("t4_err_at_d3", 32'(t_err - t_d3), 1);
    drive_frame(S7, S0, S0, S0);
    drive_frame(S7, S0, S0, S0);
    idle(4);
    check("t4_valid_cnt", 32'(n_valid - base_v), 1);
    check("t4_number", 32'(number_out), 7);
    check("t4_latency", 32'(lat_valid), 6);
    idle(100);

    // Display stops after digit 1: timeout back to SYNC
    snap();
    show_digit(0, S5);
    show_digit(1, S5);
    idle(100);
    check("t5_err_cnt", 32'(n_ferr - base_e), 1);
    check("t5_timeout_latency", 32'((t_err - t_smp >= 64) && (t_err - t_smp <= 65)), 1);
    check("t5_state", 32'(dut.state), 32'(SYNC));
    check("t5_no_valid", 32'(n_valid - base_v), 0);
    check("t5_number_kept", 32'(number_out), 7);

    // Reset in the middle of the second "9999" frame
    snap();
    drive_frame(S9, S9, S9, S9);
    show_digit(0, S9);
    show_digit(1, S9);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_number", 32'(number_out), 0);
    check("t6_rst_valid", 32'(number_valid), 0);
    check("t6_rst_ferr", 32'(frame_error), 0);
    check("t6_rst_sticky", 32'(err_sticky), 0);
    check("t6_rst_state", 32'(dut.state), 32'(SYNC));
    @(negedge clk);
    reset = 1'b0;
    snap();
    drive_frame(S9, S9, S9, S9);
    drive_frame(S9, S9, S9, S9);
    idle(4);
    check("t6_valid_cnt", 32'(n_valid - base_v), 1);
    check("t6_number", 32'(number_out), 9999);
    check("t6_latency", 32'(lat_valid), 6);
    check("t6_no_err", 32'(n_ferr - base_e), 0);
    check("t6_sticky_clear", 32'(err_sticky), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
